// File: rtl/frame_pkg.sv
// Shared types and width helpers for the frame pooler.
package frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSof,
    StCapture,
    StDone
  } state_e;

  // Counter width able to hold values 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pool_accum.sv
// Bank of per-column block accumulators: clear-all, per-column load/add, and read of the
// running sum including the current sample.
module pool_accum #(
  parameter int unsigned NCol = 4,
  parameter int unsigned AccW = 10,
  parameter int unsigned DatW = 8,
  parameter int unsigned ColW = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_all_i,
  input  logic            en_i,
  input  logic            load_i,
  input  logic [ColW-1:0] col_i,
  input  logic [DatW-1:0] din_i,
  output logic [AccW-1:0] sum_o
);

  logic [AccW-1:0] acc_q [NCol];
  logic [AccW-1:0] acc_d [NCol];
  logic [AccW-1:0] base;

  // load_i starts a new block: the column restarts from the current sample.
  assign base  = load_i ? '0 : acc_q[col_i];
  assign sum_o = base + AccW'(din_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_all_i) begin
      for (int unsigned i = 0; i < NCol; i++) acc_d[i] = '0;
    end
    if (en_i) acc_d[col_i] = sum_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NCol; i++) acc_q[i] <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/frame_pooler.sv
// Captures a window of one armed frame, average-pools SCALExSCALE blocks into a shadow image
// and publishes the whole image at once with a one-cycle valid pulse.
module frame_pooler
  import frame_pkg::*;
#(
  parameter int unsigned IN_PIX_W  = 8,
  parameter int unsigned OUT_PIX_W = 6,
  parameter int unsigned OUT_W     = 28,
  parameter int unsigned OUT_H     = 28,
  parameter int unsigned SCALE     = 16,
  parameter int unsigned X_OFF     = 96,
  parameter int unsigned Y_OFF     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 invert,
  input  logic                 pix_valid,
  input  logic [IN_PIX_W-1:0]  pix_data,
  input  logic                 sof,
  input  logic                 eol,
  output logic                 busy,
  output logic [OUT_PIX_W-1:0] pixels [0:OUT_W*OUT_H-1],
  output logic                 valid
);

  localparam int unsigned LogS = $clog2(SCALE);
  localparam int unsigned AccW = IN_PIX_W + 2 * LogS;
  localparam int unsigned XEnd = X_OFF + OUT_W * SCALE;
  localparam int unsigned YEnd = Y_OFF + OUT_H * SCALE;
  localparam int unsigned XW   = cnt_w(XEnd + 1);
  localparam int unsigned YW   = cnt_w(YEnd + 1);
  localparam int unsigned ColW = cnt_w(OUT_W);
  localparam int unsigned NPix = OUT_W * OUT_H;
  localparam int unsigned IdxW = cnt_w(NPix);
  localparam int unsigned OutShift = 2 * LogS + IN_PIX_W - OUT_PIX_W;

  localparam logic [XW-1:0] XOffC  = XW'(X_OFF);
  localparam logic [XW-1:0] XEndC  = XW'(XEnd);
  localparam logic [XW-1:0] XLastC = XW'(XEnd - 1);
  localparam logic [YW-1:0] YOffC  = YW'(Y_OFF);
  localparam logic [YW-1:0] YEndC  = YW'(YEnd);
  localparam logic [YW-1:0] YLastC = YW'(YEnd - 1);

  state_e state_q, state_d;
  logic [XW-1:0] x_q, x_d, cx, wx;
  logic [YW-1:0] y_q, y_d, cy, wy, band;
  logic [ColW-1:0] col;
  logic inv_q, inv_d, inv_cur;
  logic wr_q, wr_d, copy_q, copy_d, valid_q;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [OUT_PIX_W-1:0] wval_q, wval_d, out_raw;
  logic [OUT_PIX_W-1:0] shadow_q [NPix];
  logic [OUT_PIX_W-1:0] shadow_d [NPix];
  logic [OUT_PIX_W-1:0] pix_q [NPix];
  logic [OUT_PIX_W-1:0] pix_d [NPix];
  logic [AccW-1:0] sum;
  logic accept, in_win, first, last, final_px;

  assign accept  = pix_valid && ((state_q == StCapture) || ((state_q == StWaitSof) && sof));
  assign cx      = sof ? '0 : x_q;
  assign cy      = sof ? '0 : y_q;
  assign in_win  = (cx >= XOffC) && (cx < XEndC) && (cy >= YOffC) && (cy < YEndC);
  assign wx      = cx - XOffC;
  assign wy      = cy - YOffC;
  assign col     = ColW'(wx >> LogS);
  assign band    = wy >> LogS;
  assign first   = (wx[LogS-1:0] == '0) && (wy[LogS-1:0] == '0);
  assign last    = (wx[LogS-1:0] == '1) && (wy[LogS-1:0] == '1);
  assign final_px = accept && in_win && (cx == XLastC) && (cy == YLastC);
  assign inv_cur = sof ? invert : inv_q;
  // Divide by SCALE^2 and keep the top OUT_PIX_W bits of the average in one shift.
  assign out_raw = OUT_PIX_W'(sum >> OutShift);

  pool_accum #(
    .NCol (OUT_W),
    .AccW (AccW),
    .DatW (IN_PIX_W),
    .ColW (ColW)
  ) u_accum (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_all_i (accept && sof),
    .en_i      (accept && in_win),
    .load_i    (first),
    .col_i     (col),
    .din_i     (pix_data),
    .sum_o     (sum)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    inv_d   = inv_q;
    unique case (state_q)
      StIdle:    if (arm) state_d = StWaitSof;
      StWaitSof: if (final_px) state_d = StDone; else if (accept) state_d = StCapture;
      StCapture: if (final_px) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (accept) begin
      if (sof) inv_d = invert;
      // Coordinates saturate past the window so long lines/frames never wrap back into it.
      if (eol) begin
        x_d = '0;
        y_d = (cy == YEndC) ? cy : cy + 1'b1;
      end else begin
        x_d = (cx == XEndC) ? cx : cx + 1'b1;
        y_d = cy;
      end
    end
  end

  always_comb begin
    wr_d     = accept && in_win && last;
    idx_d    = IdxW'(32'(band) * OUT_W + 32'(col));
    wval_d   = inv_cur ? ~out_raw : out_raw;
    copy_d   = (state_q == StDone);
    shadow_d = shadow_q;
    if (wr_q) shadow_d[idx_q] = wval_q;
    pix_d = pix_q;
    if (copy_q) pix_d = shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      inv_q   <= 1'b0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wval_q  <= '0;
      copy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int unsigned i = 0; i < NPix; i++) begin
        shadow_q[i] <= '0;
        pix_q[i]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      inv_q    <= inv_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      wval_q   <= wval_d;
      copy_q   <= copy_d;
      valid_q  <= copy_q;
      shadow_q <= shadow_d;
      pix_q    <= pix_d;
    end
  end

  assign busy  = (state_q == StWaitSof) || (state_q == StCapture);
  assign valid = valid_q;

  always_comb begin
    for (int unsigned i = 0; i < NPix; i++) pixels[i] = pix_q[i];
  end

endmodule

// File: tb/tb_frame_pooler.sv
// Directed bench for frame_pooler with a 4x4 output, 2x2 blocks and a 12x12 input frame.
module tb_frame_pooler;

  localparam int NP = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arm = 1'b0;
  logic       invert = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       sof = 1'b0;
  logic       eol = 1'b0;
  logic       busy;
  logic       valid;
  logic [5:0] pixels [0:NP-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = -100;
  int acc_cyc = -1;

  frame_pooler #(
    .IN_PIX_W  (8),
    .OUT_PIX_W (6),
    .OUT_W     (4),
    .OUT_H     (4),
    .SCALE     (2),
    .X_OFF     (1),
    .Y_OFF     (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm       (arm),
    .invert    (invert),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .sof       (sof),
    .eol       (eol),
    .busy      (busy),
    .pixels    (pixels),
    .valid     (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pixels(input string tag, input int mode);
    for (int i = 0; i < NP; i++) begin
      int e;
      case (mode)
        0:       e = 0;
        1:       e = 32;
        2:       e = 63 - 4 * i;
        default: e = 63;
      endcase
      chk($sformatf("%s[%0d]", tag, i), 32'(pixels[i]), e);
    end
  endtask

  task automatic px(input logic [7:0] d, input logic s, input logic e, input int gx, input int gy);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = d;
    sof       = s;
    eol       = e;
    arm       = 1'b0;
    @(posedge clk);
    #1;
    if (gx == 8 && gy == 8) acc_cyc = cyc;
  endtask

  // mode 0: constant val; mode 1: gradient 16*(bx+4*by) inside the window.
  task automatic frame(input int mode, input logic [7:0] val, input bit gap, input int stop_row,
                       input bit arm_mid);
    acc_cyc = -1;
    for (int y = 0; y < 12; y++) begin
      if (y == stop_row) break;
      for (int x = 0; x < 12; x++) begin
        logic [7:0] d;
        d = val;
        if (mode == 1)
          d = (x >= 1 && x <= 8 && y >= 1 && y <= 8) ?
              8'(16 * ((x - 1) / 2 + 4 * ((y - 1) / 2))) : 8'h00;
        px(d, (x == 0 && y == 0), (x == 11), x, y);
        if (gap) begin
          // Unqualified sof/eol must be ignored.
          @(negedge clk);
          pix_valid = 1'b0;
          sof       = 1'b1;
          eol       = 1'b1;
          arm       = arm_mid && (y == 3) && (x == 0);
        end
      end
    end
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    eol       = 1'b0;
    arm       = 1'b0;
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk_pixels("rst_pix", 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Constant frame
    pulse_arm();
    chk("armed_busy", 32'(busy), 1);
    frame(0, 8'h80, 1'b0, 99, 1'b0);
    repeat (5) @(negedge clk);
    chk("const_vcnt", valid_cnt, 1);
    chk("const_lat", valid_cyc, acc_cyc + 2);
    chk("const_busy", 32'(busy), 0);
    chk_pixels("const_pix", 1);

    // Inverted gradient
    invert = 1'b1;
    pulse_arm();
    frame(1, 8'h00, 1'b0, 99, 1'b0);
    invert = 1'b0;
    repeat (5) @(negedge clk);
    chk("grad_vcnt", valid_cnt, 2);
    chk("grad_lat", valid_cyc, acc_cyc + 2);
    chk_pixels("grad_pix", 2);

    // Restart on sof mid-frame
    pulse_arm();
    frame(0, 8'hFF, 1'b0, 5, 1'b0);
    repeat (3) @(negedge clk);
    chk("part_busy", 32'(busy), 1);
    chk("part_vcnt", valid_cnt, 2);
    chk_pixels("part_hold", 2);
    frame(0, 8'hFF, 1'b0, 99, 1'b0);
    repeat (5) @(negedge clk);
    chk("rest_vcnt", valid_cnt, 3);
    chk("rest_lat", valid_cyc, acc_cyc + 2);
    chk_pixels("rest_pix", 3);

    // Reset mid-capture
    pulse_arm();
    frame(0, 8'h80, 1'b0, 4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk_pixels("mid_rst_pix", 0);
    rst_n = 1'b1;
    frame(0, 8'h80, 1'b0, 99, 1'b0);
    repeat (5) @(negedge clk);
    chk("noarm_vcnt", valid_cnt, 3);
    chk("noarm_busy", 32'(busy), 0);
    chk_pixels("noarm_pix", 0);
    pulse_arm();
    frame(0, 8'hFF, 1'b0, 99, 1'b0);
    repeat (5) @(negedge clk);
    chk("rearm_vcnt", valid_cnt, 4);
    chk_pixels("rearm_pix", 3);

    // Arm held in idle, then gapped input with a stray arm during capture
    @(negedge clk);
    arm = 1'b1;
    repeat (3) @(negedge clk);
    arm = 1'b0;
    chk("hold_arm_busy", 32'(busy), 1);
    frame(0, 8'h80, 1'b1, 99, 1'b1);
    repeat (5) @(negedge clk);
    chk("gap_vcnt", valid_cnt, 5);
    chk("gap_lat", valid_cyc, acc_cyc + 2);
    chk("gap_busy", 32'(busy), 0);
    chk_pixels("gap_pix", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
